// File: rtl/id_ex_issue_stage_pkg.sv
// Shared definitions for the dual-lane ID/EX issue stage: forward-select
// codes, FSM state encoding and a helper that decodes forward coverage.
package id_ex_issue_stage_pkg;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_SRC1 = 2'd1;
    localparam logic [1:0] FWD_SRC2 = 2'd2;
    localparam logic [1:0] FWD_BOTH = 2'd3;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // True when a forward code supplies the given source (src2 = 0 -> src1).
    function automatic logic fwd_covers(input logic [1:0] code, input logic src2);
        if (src2) begin
            return (code == FWD_SRC2) || (code == FWD_BOTH);
        end
        return (code == FWD_SRC1) || (code == FWD_BOTH);
    endfunction

endpackage

// File: rtl/id_ex_issue_stage_if.sv
// Decode-side, bypass-side and EX-side signals of the issue stage.
// The master drives the decode/forwarding/control inputs; the slave is the stage.
interface id_ex_issue_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            dec_valid_1;
    logic            dec_valid_2;
    logic [4:0]      dec_dstreg_num_1;
    logic [4:0]      dec_srcreg1_num_2;
    logic [4:0]      dec_srcreg2_num_2;
    logic [XLEN-1:0] rf_rs1_1;
    logic [XLEN-1:0] rf_rs2_1;
    logic [XLEN-1:0] rf_rs1_2;
    logic [XLEN-1:0] rf_rs2_2;
    logic [1:0]      a_forward_1;
    logic [1:0]      b_forward_1;
    logic [1:0]      c_forward_1;
    logic [1:0]      a_forward_2;
    logic [1:0]      b_forward_2;
    logic [1:0]      c_forward_2;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] mem_result;
    logic [XLEN-1:0] wb_result;
    logic            ex_is_load;
    logic            ex_hold;
    logic            flush;
    logic [XLEN-1:0] ex_op1_1;
    logic [XLEN-1:0] ex_op2_1;
    logic [XLEN-1:0] ex_op1_2;
    logic [XLEN-1:0] ex_op2_2;
    logic            ex_valid_1;
    logic            ex_valid_2;
    logic            id_stall;

    modport master (
        output dec_valid_1, dec_valid_2, dec_dstreg_num_1,
        output dec_srcreg1_num_2, dec_srcreg2_num_2,
        output rf_rs1_1, rf_rs2_1, rf_rs1_2, rf_rs2_2,
        output a_forward_1, b_forward_1, c_forward_1,
        output a_forward_2, b_forward_2, c_forward_2,
        output ex_result, mem_result, wb_result,
        output ex_is_load, ex_hold, flush,
        input  ex_op1_1, ex_op2_1, ex_op1_2, ex_op2_2,
        input  ex_valid_1, ex_valid_2, id_stall
    );

    modport slave (
        input  dec_valid_1, dec_valid_2, dec_dstreg_num_1,
        input  dec_srcreg1_num_2, dec_srcreg2_num_2,
        input  rf_rs1_1, rf_rs2_1, rf_rs1_2, rf_rs2_2,
        input  a_forward_1, b_forward_1, c_forward_1,
        input  a_forward_2, b_forward_2, c_forward_2,
        input  ex_result, mem_result, wb_result,
        input  ex_is_load, ex_hold, flush,
        output ex_op1_1, ex_op2_1, ex_op1_2, ex_op2_2,
        output ex_valid_1, ex_valid_2, id_stall
    );
endinterface

// File: rtl/id_ex_issue_stage_operand_bypass_mux.sv
// Per-lane operand bypass: picks EX, then MEM, then WB result, else the
// register-file value, independently for each of the two sources.
module operand_bypass_mux
    import id_ex_issue_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      a_forward,
    input  logic [1:0]      b_forward,
    input  logic [1:0]      c_forward,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2
);

    // Source 1 select with strict EX > MEM > WB priority.
    always_comb begin
        op1 = rf_rs1;
        if (fwd_covers(a_forward, 1'b0)) begin
            op1 = ex_result;
        end else if (fwd_covers(b_forward, 1'b0)) begin
            op1 = mem_result;
        end else if (fwd_covers(c_forward, 1'b0)) begin
            op1 = wb_result;
        end
    end

    // Source 2 select with strict EX > MEM > WB priority.
    always_comb begin
        op2 = rf_rs2;
        if (fwd_covers(a_forward, 1'b1)) begin
            op2 = ex_result;
        end else if (fwd_covers(b_forward, 1'b1)) begin
            op2 = mem_result;
        end else if (fwd_covers(c_forward, 1'b1)) begin
            op2 = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_issue_stage.sv
// Dual-lane ID/EX issue register. Bypasses operands per lane, registers them
// into EX, and inserts bubbles for load-use and intra-bundle RAW hazards.
module id_ex_issue_stage
    import id_ex_issue_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic                clk,
    input logic                rst,
    id_ex_issue_stage_if.slave bus
);

    logic [XLEN-1:0] op1_1;
    logic [XLEN-1:0] op2_1;
    logic [XLEN-1:0] op1_2;
    logic [XLEN-1:0] op2_2;
    logic            load_use_1;
    logic            load_use_2;
    logic            intra;
    state_t          state;

    operand_bypass_mux #(.XLEN(XLEN)) u_mux_1 (
        .a_forward  (bus.a_forward_1),
        .b_forward  (bus.b_forward_1),
        .c_forward  (bus.c_forward_1),
        .rf_rs1     (bus.rf_rs1_1),
        .rf_rs2     (bus.rf_rs2_1),
        .ex_result  (bus.ex_result),
        .mem_result (bus.mem_result),
        .wb_result  (bus.wb_result),
        .op1        (op1_1),
        .op2        (op2_1)
    );

    operand_bypass_mux #(.XLEN(XLEN)) u_mux_2 (
        .a_forward  (bus.a_forward_2),
        .b_forward  (bus.b_forward_2),
        .c_forward  (bus.c_forward_2),
        .rf_rs1     (bus.rf_rs1_2),
        .rf_rs2     (bus.rf_rs2_2),
        .ex_result  (bus.ex_result),
        .mem_result (bus.mem_result),
        .wb_result  (bus.wb_result),
        .op1        (op1_2),
        .op2        (op2_2)
    );

    // Hazard detection: an EX-forwarded source from a load is not ready yet;
    // lane 2 reading lane 1's destination cannot be forwarded within the bundle.
    always_comb begin
        load_use_1 = bus.dec_valid_1 && bus.ex_is_load && (bus.a_forward_1 != FWD_NONE);
        load_use_2 = bus.dec_valid_2 && bus.ex_is_load && (bus.a_forward_2 != FWD_NONE);
        intra      = bus.dec_valid_1 && bus.dec_valid_2 && (bus.dec_dstreg_num_1 != 5'd0) &&
                     ((bus.dec_dstreg_num_1 == bus.dec_srcreg1_num_2) ||
                      (bus.dec_dstreg_num_1 == bus.dec_srcreg2_num_2));
    end

    // Decode stall: flush overrides hold, hold overrides hazard stalls.
    always_comb begin
        bus.id_stall = 1'b0;
        if (rst || bus.flush) begin
            bus.id_stall = 1'b0;
        end else if (bus.ex_hold) begin
            bus.id_stall = 1'b1;
        end else if (state == RUN) begin
            bus.id_stall = load_use_1 || load_use_2 || intra;
        end else begin
            bus.id_stall = load_use_2;
        end
    end

    // EX registers and issue FSM. Operands load every non-held cycle; lanes
    // that are not issued carry don't-care operands with their valid cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_op1_1   <= '0;
            bus.ex_op2_1   <= '0;
            bus.ex_op1_2   <= '0;
            bus.ex_op2_2   <= '0;
            bus.ex_valid_1 <= 1'b0;
            bus.ex_valid_2 <= 1'b0;
            state          <= RUN;
        end else if (bus.flush) begin
            bus.ex_valid_1 <= 1'b0;
            bus.ex_valid_2 <= 1'b0;
            state          <= RUN;
        end else if (!bus.ex_hold) begin
            bus.ex_op1_1 <= op1_1;
            bus.ex_op2_1 <= op2_1;
            bus.ex_op1_2 <= op1_2;
            bus.ex_op2_2 <= op2_2;
            case (state)
                RUN: begin
                    if (load_use_1 || load_use_2) begin
                        bus.ex_valid_1 <= 1'b0;
                        bus.ex_valid_2 <= 1'b0;
                    end else if (intra) begin
                        bus.ex_valid_1 <= 1'b1;
                        bus.ex_valid_2 <= 1'b0;
                        state          <= SPLIT;
                    end else begin
                        bus.ex_valid_1 <= bus.dec_valid_1;
                        bus.ex_valid_2 <= bus.dec_valid_2;
                    end
                end
                SPLIT: begin
                    bus.ex_valid_1 <= 1'b0;
                    if (load_use_2) begin
                        bus.ex_valid_2 <= 1'b0;
                    end else begin
                        bus.ex_valid_2 <= bus.dec_valid_2;
                        state          <= RUN;
                    end
                end
                default: begin
                    bus.ex_valid_1 <= 1'b0;
                    bus.ex_valid_2 <= 1'b0;
                    state          <= RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
- Dual-lane ID/EX issue register for the two-lane decode path.
- Consumes the per-lane EX/MEM/WB forward-select codes produced by the forwarding logic. Resolves each source operand by bypass muxing and registers both lanes' operands into EX.
- Detects two hazards the forward codes cannot cover: load-use and intra-bundle RAW (lane 2 reads lane 1's destination). It inserts bubbles and stalls decode as needed.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid_1 / dec_valid_2  in  1  decode lane holds a valid instruction
- dec_dstreg_num_1  in  5  lane 1 destination register
- dec_srcreg1_num_2 / dec_srcreg2_num_2  in  5  lane 2 source registers
- rf_rs1_1 / rf_rs2_1 / rf_rs1_2 / rf_rs2_2  in  XLEN  register-file read data per lane and source
- a_forward_1 / b_forward_1 / c_forward_1  in  2  lane 1 EX/MEM/WB forward codes
- a_forward_2 / b_forward_2 / c_forward_2  in  2  lane 2 EX/MEM/WB forward codes
- Forward code encoding: 0 = none, 1 = src1, 2 = src2, 3 = both.
- ex_result / mem_result / wb_result  in  XLEN  stage results for bypass
- ex_is_load  in  1  instruction now in EX is a load (its result is not yet valid)
- ex_hold  in  1  downstream backpressure: freeze EX registers
- flush  in  1  branch redirect: kill decode bundle
- ex_op1_1 / ex_op2_1 / ex_op1_2 / ex_op2_2  out  XLEN  registered EX operands
- ex_valid_1 / ex_valid_2  out  1  registered EX lane valid
- id_stall  out  1  combinational: decode must hold its bundle this cycle

Behaviour:
- Reset: all ex_op* = 0, ex_valid_* = 0, state = RUN. id_stall = 0 while rst is high.
- Operand select, per lane and per source:
  - EX code covers the source (src1: code 1 or 3; src2: code 2 or 3) -> ex_result.
  - else MEM code covers it -> mem_result.
  - else WB code covers it -> wb_result.
  - else rf value.
  - Priority is strictly EX > MEM > WB.
- Load-use hazard for lane k: dec_valid_k and ex_is_load and a_forward_k != 0.
- Intra-bundle RAW (intra): dec_valid_1 and dec_valid_2 and dec_dstreg_num_1 != 0 and dec_dstreg_num_1 equals either lane 2 source.
- Priority order each cycle: flush > ex_hold > FSM.
- flush: both ex_valid <= 0, state <= RUN, id_stall = 0. This applies mid-SPLIT as well.
- ex_hold (no flush): all EX registers and state keep their values; id_stall = 1.
- FSM state RUN:
  - Any lane load-use -> both ex_valid <= 0, id_stall = 1, stay RUN. The next cycle re-evaluates with the load in MEM.
  - else if intra -> issue lane 1 only (ex_valid_1 <= 1, ex_valid_2 <= 0), id_stall = 1, go SPLIT.
  - else -> issue both lanes with ex_valid_k <= dec_valid_k, id_stall = 0.
- FSM state SPLIT: lane 1 is already issued, and decode still presents the same bundle.
  - Lane 1 is masked (ex_valid_1 <= 0).
  - If lane 2 load-use (lane 1 was a load) -> ex_valid_2 <= 0, id_stall = 1, stay SPLIT.
  - else -> ex_valid_2 <= dec_valid_2 with lane 2 operands (lane 1's result now arrives via the EX forward code), id_stall = 0, go RUN.
- Invalid lanes: operand registers may load don't-care data, but ex_valid must be 0.
- Latency: one cycle from decode to EX registers. Bubbles cost exactly one cycle per hazard occurrence.
- Register x0 is never a hazard source: rely on dstreg != 0 for the intra check; the forward codes already exclude x0.

Decomposition:
- Shared package: forward-code constants (FWD_NONE = 0, FWD_SRC1 = 1, FWD_SRC2 = 2, FWD_BOTH = 3) and the FSM state encoding (RUN, SPLIT).
- One natural sub-module: operand_bypass_mux, instantiated twice (one per lane). It takes the three codes, the two rf values and the three results, and outputs two operands.

Test Plan:
- Bypass priority: lane 1 a=1, b=1, c=1, ex_result=0x11, mem_result=0x22, wb_result=0x33 -> next cycle ex_op1_1 = 0x11. With a=0: 0x22. With a=b=0: 0x33. With all codes 0: rf_rs1_1.
- Both sources from EX: a_forward_2 = 3, ex_result = 0xDEAD -> ex_op1_2 = ex_op2_2 = 0xDEAD, ex_valid_2 = 1.
- Load-use: ex_is_load = 1, a_forward_1 = 2 -> id_stall = 1 and both ex_valid = 0 for one cycle. Next cycle with ex_is_load = 0 and b_forward_1 = 2 -> lane 1 issues with ex_op2_1 = mem_result.
- Intra-bundle RAW: dec_dstreg_num_1 = 5, dec_srcreg1_num_2 = 5, both valid -> cycle 1: ex_valid_1 = 1, ex_valid_2 = 0, id_stall = 1. Cycle 2: ex_valid_1 = 0, ex_valid_2 = 1, ex_op1_2 = ex_result (a_forward_2 = 1), id_stall = 0. Repeat with dec_dstreg_num_1 = 0 -> no split.
- Flush mid-SPLIT: enter SPLIT, assert flush -> ex_valid_1 = ex_valid_2 = 0, state RUN, id_stall = 0.
- Hold and reset: ex_hold for 3 cycles keeps outputs unchanged with id_stall = 1. Asserting rst mid-stream -> all outputs 0 on the next edge, state RUN.
